// File: rtl/serial_tx_arbiter_if.sv
// Requester/converter bundle of the serial transmit arbiter.
// The slave side is the arbiter; the master side is the requesters plus the converter.
interface serial_tx_arbiter_if #(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH          = 4,
  parameter int NUM_REQ             = 4
);
  logic [NUM_REQ-1:0]                     req;
  logic [NUM_REQ*PARALLEL_PORT_WIDTH-1:0] req_data;
  logic [NUM_REQ*BIT_LENGTH-1:0]          req_len;
  logic [NUM_REQ-1:0]                     grant;
  logic [NUM_REQ-1:0]                     ack;
  logic                                   err;
  logic                                   busy;
  logic                                   tx_dv;
  logic [PARALLEL_PORT_WIDTH-1:0]         tx_din;
  logic [BIT_LENGTH-1:0]                  tx_bit_length;
  logic                                   tx_data_sent;

  modport master (
    output req, req_data, req_len, tx_data_sent,
    input  grant, ack, err, busy, tx_dv, tx_din, tx_bit_length
  );

  modport slave (
    input  req, req_data, req_len, tx_data_sent,
    output grant, ack, err, busy, tx_dv, tx_din, tx_bit_length
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial converter among NUM_REQ
// requesters; each granted word is loaded, awaited (with timeout) and acknowledged.
module serial_tx_arbiter #(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH          = 4,
  parameter int NUM_REQ             = 4,
  parameter int TIMEOUT             = 40
) (
  input logic                clk,
  input logic                rstn,
  serial_tx_arbiter_if.slave bus
);
  localparam int W  = PARALLEL_PORT_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         owner;
  logic [CW-1:0]         wait_cnt;
  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         cand_idx;
  int                    cand;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [W-1:0]          win_data;
  logic [BIT_LENGTH-1:0] win_len;

  function automatic logic [BIT_LENGTH-1:0] clamp_len(input logic [BIT_LENGTH-1:0] len);
    if (int'(len) > W) return BIT_LENGTH'(W);
    return len;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Round-robin search starting at ptr, then a constant-index mux of the winner's word.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = ptr;
    cand       = 0;
    cand_idx   = '0;
    win_onehot = '0;
    win_data   = '0;
    win_len    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PW'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PW'(k)) begin
        win_onehot[k] = 1'b1;
        win_data      = bus.req_data[k*W +: W];
        win_len       = bus.req_len[k*BIT_LENGTH +: BIT_LENGTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      ptr               <= '0;
      owner             <= '0;
      wait_cnt          <= '0;
      bus.grant         <= '0;
      bus.ack           <= '0;
      bus.err           <= 1'b0;
      bus.busy          <= 1'b0;
      bus.tx_dv         <= 1'b0;
      bus.tx_din        <= '0;
      bus.tx_bit_length <= '0;
    end else begin
      bus.tx_dv <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            bus.grant         <= win_onehot;
            bus.tx_din        <= win_data;
            bus.tx_bit_length <= clamp_len(win_len);
            bus.busy          <= 1'b1;
            owner             <= win_idx;
            state             <= (win_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          bus.tx_dv <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // The first WAIT cycle coincides with the load strobe, so completion is not yet possible.
          if (wait_cnt != '0 && bus.tx_data_sent) begin
            bus.ack <= bus.grant;
            state   <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            bus.err <= 1'b1;
            bus.ack <= bus.grant;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          // A zero-length word arrives here without ack, so it spends one extra DONE cycle pulsing it.
          if (bus.ack == '0) begin
            bus.ack <= bus.grant;
          end else begin
            bus.ack   <= '0;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            ptr       <= next_idx(owner);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
